// File: rtl/hd63701_pkg.sv
// Shared definitions for the HD63701 built-in work RAM arbiter.
package hd63701_pkg;

  localparam logic [15:0] BIRAM_BASE = 16'h0080;
  localparam int          BIRAM_AW   = 7;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HACC     = 2'd1,
    SNAP_RD  = 2'd2,
    SNAP_OUT = 2'd3
  } biram_state_t;

endpackage

// File: rtl/hd63701_biram_arbiter_if.sv
// Bus bundle between the MCU core, the host/debug port, the snapshot stream and the arbiter.
// Snapshot stream: a byte moves on every cycle where snap_valid and snap_ready are both 1;
// while snap_valid=1 and snap_ready=0, snap_valid, snap_data and snap_addr are held stable.
interface hd63701_biram_arbiter_if
  import hd63701_pkg::*;
#(
  parameter int AW = BIRAM_AW
);

  logic          clken;
  logic [15:0]   core_ad;
  logic          core_wr;
  logic [7:0]    core_do;
  logic          core_en;
  logic [7:0]    core_di;

  logic          host_req;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [7:0]    host_wdata;
  logic          host_ack;
  logic [7:0]    host_rdata;

  logic          snap_start;
  logic          snap_valid;
  logic          snap_ready;
  logic [7:0]    snap_data;
  logic [AW-1:0] snap_addr;
  logic          snap_done;

  logic          busy;
  biram_state_t  dbg_state;

  modport slave (
    input  clken, core_ad, core_wr, core_do,
    input  host_req, host_we, host_addr, host_wdata,
    input  snap_start, snap_ready,
    output core_en, core_di,
    output host_ack, host_rdata,
    output snap_valid, snap_data, snap_addr, snap_done,
    output busy, dbg_state
  );

  modport master (
    output clken, core_ad, core_wr, core_do,
    output host_req, host_we, host_addr, host_wdata,
    output snap_start, snap_ready,
    input  core_en, core_di,
    input  host_ack, host_rdata,
    input  snap_valid, snap_data, snap_addr, snap_done,
    input  busy, dbg_state
  );

endinterface

// File: rtl/hd63701_biram_sp.sv
// Single-port synchronous byte RAM; read data appears the cycle after the address.
module hd63701_biram_sp #(
  parameter int AW = 7
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    din,
  output logic [7:0]    dout
);

  logic [7:0] r_mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[addr] <= din;
    end
    dout <= r_mem[addr];
  end

endmodule

// File: rtl/hd63701_biram_arbiter.sv
// Work RAM arbiter: the core owns every cycle it addresses the window; host accesses and
// the snapshot streamer use the remaining free cycles.
module hd63701_biram_arbiter
  import hd63701_pkg::*;
#(
  parameter int          AW   = BIRAM_AW,
  parameter logic [15:0] BASE = BIRAM_BASE
) (
  input  logic                      CLKx2,
  input  logic                      RST,
  hd63701_biram_arbiter_if.slave    bus
);

  localparam logic [AW-1:0] LAST_PTR = '1;

  biram_state_t  r_state;
  biram_state_t  w_state_nxt;
  logic [AW-1:0] r_ptr;
  logic [AW-1:0] w_ptr_nxt;

  logic          w_core_en;
  logic          w_core_gnt;
  logic          w_free;
  logic [15:0]   w_core_off;

  logic          w_host_issue;
  logic          w_snap_issue;
  logic          w_snap_done_nxt;

  logic          r_core_sel;
  logic          r_host_sel;
  logic          r_snap_sel;
  logic          r_snap_done;
  logic [7:0]    r_core_di;
  logic [7:0]    r_host_rdata;
  logic [7:0]    r_snap_data;

  logic          w_ram_we;
  logic [AW-1:0] w_ram_addr;
  logic [7:0]    w_ram_din;
  logic [7:0]    w_ram_dout;

  // In-window test: offset from BASE must fit in AW bits once the address is at or above BASE.
  assign w_core_off = bus.core_ad - BASE;
  assign w_core_en  = (bus.core_ad >= BASE) && (w_core_off[15:AW] == '0);
  assign w_core_gnt = bus.clken & w_core_en;
  assign w_free     = ~w_core_gnt;

  always_comb begin
    w_state_nxt     = r_state;
    w_ptr_nxt       = r_ptr;
    w_host_issue    = 1'b0;
    w_snap_issue    = 1'b0;
    w_snap_done_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.snap_start) begin
          w_state_nxt = SNAP_RD;
          w_ptr_nxt   = '0;
        end else if (bus.host_req && w_free) begin
          w_host_issue = 1'b1;
          w_state_nxt  = HACC;
        end
      end
      HACC: begin
        w_state_nxt = IDLE;
      end
      SNAP_RD: begin
        if (w_free) begin
          w_snap_issue = 1'b1;
          w_state_nxt  = SNAP_OUT;
        end
      end
      SNAP_OUT: begin
        if (bus.snap_ready) begin
          if (r_ptr == LAST_PTR) begin
            w_snap_done_nxt = 1'b1;
            w_state_nxt     = IDLE;
          end else begin
            w_ptr_nxt   = r_ptr + AW'(1);
            w_state_nxt = SNAP_RD;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // The snapshot read address is the pointer, so it is the default when nothing else wants the port.
  always_comb begin
    w_ram_we   = 1'b0;
    w_ram_addr = r_ptr;
    w_ram_din  = bus.host_wdata;
    if (w_core_gnt) begin
      w_ram_we   = bus.core_wr;
      w_ram_addr = w_core_off[AW-1:0];
      w_ram_din  = bus.core_do;
    end else if (w_host_issue && !RST) begin
      w_ram_we   = bus.host_we;
      w_ram_addr = bus.host_addr;
    end
  end

  hd63701_biram_sp #(
    .AW (AW)
  ) u_ram (
    .clk  (CLKx2),
    .we   (w_ram_we),
    .addr (w_ram_addr),
    .din  (w_ram_din),
    .dout (w_ram_dout)
  );

  always_ff @(posedge CLKx2) begin
    if (RST) begin
      r_state      <= IDLE;
      r_ptr        <= '0;
      r_core_sel   <= 1'b0;
      r_host_sel   <= 1'b0;
      r_snap_sel   <= 1'b0;
      r_snap_done  <= 1'b0;
      r_core_di    <= 8'h00;
      r_host_rdata <= 8'h00;
      r_snap_data  <= 8'h00;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_core_sel  <= w_core_gnt & ~bus.core_wr;
      r_host_sel  <= w_host_issue & ~bus.host_we;
      r_snap_sel  <= w_snap_issue;
      r_snap_done <= w_snap_done_nxt;
      if (r_core_sel) begin
        r_core_di <= w_ram_dout;
      end
      if (r_host_sel) begin
        r_host_rdata <= w_ram_dout;
      end
      if (r_snap_sel) begin
        r_snap_data <= w_ram_dout;
      end
    end
  end

  // Each consumer sees the RAM output directly in the cycle its read lands, then a held copy,
  // so later accesses by other requesters never disturb it.
  assign bus.core_en    = w_core_en;
  assign bus.core_di    = r_core_sel ? w_ram_dout : r_core_di;
  assign bus.host_ack   = (r_state == HACC);
  assign bus.host_rdata = r_host_sel ? w_ram_dout : r_host_rdata;
  assign bus.snap_valid = (r_state == SNAP_OUT);
  assign bus.snap_data  = r_snap_sel ? w_ram_dout : r_snap_data;
  assign bus.snap_addr  = r_ptr;
  assign bus.snap_done  = r_snap_done;
  assign bus.busy       = (r_state != IDLE);
  assign bus.dbg_state  = r_state;

endmodule

// File: tb/tb_hd63701_biram_arbiter.sv
// Self-checking bench for the HD63701 work RAM arbiter: directed core/host/snapshot traffic
// with expected responses queued by the stimulus and consumed by a negedge monitor.
module tb_hd63701_biram_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int   n_checks   = 0;
  int   n_fail     = 0;
  int   done_cnt   = 0;
  bit   rand_ready = 1'b1;
  logic core_pend  = 1'b0;
  int   lat;

  logic [7:0]  core_exp_q[$];
  logic [8:0]  host_exp_q[$];
  logic [14:0] snap_exp_q[$];

  logic [7:0]  e8;
  logic [8:0]  e9;
  logic [14:0] e15;

  hd63701_biram_arbiter_if #(.AW(7)) bus ();

  hd63701_biram_arbiter #(
    .AW   (7),
    .BASE (16'h0080)
  ) dut (
    .CLKx2 (clk),
    .RST   (rst),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  function automatic bit in_win(input logic [15:0] a);
    return (a >= 16'h0080) && (a <= 16'h00FF);
  endfunction

  // ---------------- snapshot consumer ----------------
  always @(posedge clk) begin
    #1;
    bus.snap_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (core_pend) begin
      chk("core_rd_expected", 32'(core_exp_q.size() != 0), 32'd1);
      if (core_exp_q.size() != 0) begin
        e8 = core_exp_q.pop_front();
        chk("core_di", 32'(bus.core_di), 32'(e8));
      end
    end
    core_pend = bus.clken && in_win(bus.core_ad) && !bus.core_wr && !rst;

    if (bus.host_ack) begin
      chk("host_ack_expected", 32'(host_exp_q.size() != 0), 32'd1);
      if (host_exp_q.size() != 0) begin
        e9 = host_exp_q.pop_front();
        if (e9[8]) chk("host_rdata", 32'(bus.host_rdata), 32'(e9[7:0]));
      end
    end

    if (bus.snap_valid) begin
      chk("snap_expected", 32'(snap_exp_q.size() != 0), 32'd1);
      if (snap_exp_q.size() != 0) begin
        e15 = snap_exp_q[0];
        chk("snap_beat", 32'({bus.snap_addr, bus.snap_data}), 32'(e15));
        if (bus.snap_ready) void'(snap_exp_q.pop_front());
      end
    end

    if (bus.snap_done) begin
      done_cnt++;
      chk("snap_done_after_last", 32'(snap_exp_q.size()), 32'd0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic core_cycle(input logic [15:0] ad, input logic wr, input logic [7:0] d);
    @(posedge clk); #1;
    bus.clken   = 1'b1;
    bus.core_ad = ad;
    bus.core_wr = wr;
    bus.core_do = d;
    @(posedge clk); #1;
    bus.clken   = 1'b0;
    bus.core_wr = 1'b0;
  endtask

  task automatic host_access(input logic we, input logic [6:0] a, input logic [7:0] d,
                             input logic [7:0] exp_rd);
    bit got;
    host_exp_q.push_back({~we, exp_rd});
    @(posedge clk); #1;
    bus.host_req   = 1'b1;
    bus.host_we    = we;
    bus.host_addr  = a;
    bus.host_wdata = d;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.host_ack) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk("host_ack_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    bus.host_req = 1'b0;
  endtask

  // Counts negedges from the drive point until host_ack; core bus is released after drop_at.
  task automatic wait_ack_lat(input int drop_at, output int l);
    l = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (bus.host_ack) begin
        l = i;
        break;
      end
      @(posedge clk); #1;
      if (i == drop_at) begin
        bus.clken   = 1'b0;
        bus.core_wr = 1'b0;
      end
    end
    @(posedge clk); #1;
    bus.host_req = 1'b0;
  endtask

  task automatic push_snap(input int last);
    for (int i = 0; i <= last; i++) begin
      snap_exp_q.push_back({7'(i), 8'(i) ^ 8'h5A});
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1;
    bus.snap_start = 1'b1;
    @(posedge clk); #1;
    bus.snap_start = 1'b0;
  endtask

  task automatic wait_done(input int target, input string name);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done_cnt >= target) begin
        got = 1'b1;
        break;
      end
    end
    chk(name, 32'(got), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.clken      = 1'b0;
    bus.core_ad    = 16'h0000;
    bus.core_wr    = 1'b0;
    bus.core_do    = 8'h00;
    bus.host_req   = 1'b0;
    bus.host_we    = 1'b0;
    bus.host_addr  = 7'd0;
    bus.host_wdata = 8'h00;
    bus.snap_start = 1'b0;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_core_di",    32'(bus.core_di),    32'h00);
    chk("rst_host_ack",   32'(bus.host_ack),   32'h0);
    chk("rst_host_rdata", 32'(bus.host_rdata), 32'h00);
    chk("rst_snap_valid", 32'(bus.snap_valid), 32'h0);
    chk("rst_snap_data",  32'(bus.snap_data),  32'h00);
    chk("rst_snap_addr",  32'(bus.snap_addr),  32'h00);
    chk("rst_snap_done",  32'(bus.snap_done),  32'h0);
    chk("rst_busy",       32'(bus.busy),       32'h0);

    // window boundaries
    bus.core_ad = 16'h007F; #1 chk("core_en_007f", 32'(bus.core_en), 32'd0);
    bus.core_ad = 16'h0080; #1 chk("core_en_0080", 32'(bus.core_en), 32'd1);
    bus.core_ad = 16'h00FF; #1 chk("core_en_00ff", 32'(bus.core_en), 32'd1);
    bus.core_ad = 16'h0100; #1 chk("core_en_0100", 32'(bus.core_en), 32'd0);
    bus.core_ad = 16'h0000;

    // core write then read back; value held over non-RAM core cycles
    core_cycle(16'h0085, 1'b1, 8'hA5);
    core_exp_q.push_back(8'hA5);
    core_cycle(16'h0085, 1'b0, 8'h00);
    core_cycle(16'h1234, 1'b0, 8'h00);
    core_cycle(16'hF000, 1'b0, 8'h00);
    @(negedge clk);
    chk("core_di_hold", 32'(bus.core_di), 32'hA5);

    // host read of byte 5 starved by 3 core cycles on $0090
    host_exp_q.push_back({1'b1, 8'hA5});
    @(posedge clk); #1;
    bus.clken     = 1'b1;
    bus.core_ad   = 16'h0090;
    bus.core_wr   = 1'b1;
    bus.core_do   = 8'h77;
    bus.host_req  = 1'b1;
    bus.host_we   = 1'b0;
    bus.host_addr = 7'd5;
    wait_ack_lat(3, lat);
    chk("host_starved_latency", 32'(lat), 32'd5);

    // same-cycle core and host writes to byte 3: host value must be final
    host_exp_q.push_back({1'b0, 8'h00});
    @(posedge clk); #1;
    bus.clken      = 1'b1;
    bus.core_ad    = 16'h0083;
    bus.core_wr    = 1'b1;
    bus.core_do    = 8'h11;
    bus.host_req   = 1'b1;
    bus.host_we    = 1'b1;
    bus.host_addr  = 7'd3;
    bus.host_wdata = 8'h22;
    wait_ack_lat(1, lat);
    chk("host_collide_latency", 32'(lat), 32'd3);
    host_access(1'b0, 7'd3, 8'h00, 8'h22);
    core_exp_q.push_back(8'h22);
    core_cycle(16'h0083, 1'b0, 8'h00);

    // fill byte i = i ^ $5A through the host port
    for (int i = 0; i < 128; i++) begin
      host_access(1'b1, 7'(i), 8'(i) ^ 8'h5A, 8'h00);
    end
    @(negedge clk);
    chk("host_rdata_hold", 32'(bus.host_rdata), 32'h22);

    // full snapshot with a randomly stalling consumer
    rand_ready = 1'b1;
    push_snap(127);
    pulse_start();
    wait_done(1, "snap1_done_seen");
    chk("snap1_done_cnt", 32'(done_cnt), 32'd1);
    chk("snap1_busy_after", 32'(bus.busy), 32'd0);

    // snap_start beats host_req; mid-snapshot start is ignored
    push_snap(127);
    host_exp_q.push_back({1'b1, 8'h07 ^ 8'h5A});
    @(posedge clk); #1;
    bus.snap_start = 1'b1;
    bus.host_req   = 1'b1;
    bus.host_we    = 1'b0;
    bus.host_addr  = 7'd7;
    @(posedge clk); #1;
    bus.snap_start = 1'b0;
    lat = 0;
    for (int i = 1; i <= 3000; i++) begin
      @(negedge clk);
      if (bus.host_ack) begin
        lat = i;
        chk("host_after_snap_done", 32'(done_cnt), 32'd2);
        break;
      end
      if (i == 40) bus.snap_start = 1'b1;
      if (i == 41) bus.snap_start = 1'b0;
    end
    chk("host_ack_after_snap_seen", 32'(lat != 0), 32'd1);
    @(posedge clk); #1;
    bus.host_req = 1'b0;

    // reset on byte 40 aborts the snapshot
    rand_ready = 1'b0;
    push_snap(40);
    pulse_start();
    lat = 0;
    for (int i = 1; i <= 500; i++) begin
      @(negedge clk);
      if (bus.snap_valid && (bus.snap_addr == 7'd40)) begin
        rst = 1'b1;
        lat = i;
        break;
      end
    end
    chk("snap_reached_byte40", 32'(lat != 0), 32'd1);
    @(negedge clk);
    chk("abort_snap_valid", 32'(bus.snap_valid), 32'd0);
    chk("abort_busy",       32'(bus.busy),       32'd0);
    chk("abort_snap_done",  32'(bus.snap_done),  32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_no_done_cnt", 32'(done_cnt), 32'd2);
    chk("abort_snap_q_empty", 32'(snap_exp_q.size()), 32'd0);
    snap_exp_q.delete();

    // a fresh snapshot after reset starts at byte 0
    rand_ready = 1'b1;
    push_snap(127);
    pulse_start();
    wait_done(3, "snap3_done_seen");
    chk("snap3_done_cnt", 32'(done_cnt), 32'd3);
    chk("snap3_busy_after", 32'(bus.busy), 32'd0);

    repeat (4) @(negedge clk);
    chk("end_core_q_empty", 32'(core_exp_q.size()), 32'd0);
    chk("end_host_q_empty", 32'(host_exp_q.size()), 32'd0);
    chk("end_snap_q_empty", 32'(snap_exp_q.size()), 32'd0);
    chk("end_done_cnt", 32'(done_cnt), 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
